// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch and load/store ports.
// Each access spends MEM_LAT cycles in BUSY and is acknowledged for one RESP cycle.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);
    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gnt_q, gnt_d;
    logic               last_gnt_q, last_gnt_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               if_ack_q, if_ack_d;
    logic               d_ack_q, d_ack_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic               elig_if, elig_d, grant_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;

        // The port being acknowledged in RESP sits out this arbitration round.
        elig_if = if_req;
        elig_d  = d_req;
        if (state_q == RESP) begin
            elig_if = if_req & gnt_q;
            elig_d  = d_req & ~gnt_q;
        end
        grant_sel = (elig_if && elig_d) ? ~last_gnt_q : elig_d;

        case (state_q)
            IDLE, RESP: begin
                if (elig_if || elig_d) begin
                    state_d    = BUSY;
                    gnt_d      = grant_sel;
                    last_gnt_d = grant_sel;
                    cnt_d      = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!gnt_q) begin
                        if_rdata_d = mem_rdata;
                    end else if (!d_we) begin
                        d_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Memory strobes and acks are registered from the next state.
        mem_en_d = (state_d == BUSY);
        if (mem_en_d) begin
            if (gnt_d) begin
                mem_we_d    = d_we;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
            end else begin
                mem_addr_d  = if_addr;
            end
        end
        if_ack_d = (state_d == RESP) && !gnt_d;
        d_ack_d  = (state_d == RESP) && gnt_d;
    end

    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked cycle by cycle
// against a transaction-level scheduling model and a reference memory image.
module tb_mem_arbiter;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned L  = 2;

    logic          clk, reset;
    logic          if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, stall;
    logic [AW-1:0] if_addr, d_addr, mem_addr;
    logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

    logic          if_req1, if_ack1, d_req1, d_we1, d_ack1, mem_en1, mem_we1, stall1;
    logic [AW-1:0] if_addr1, d_addr1, mem_addr1;
    logic [DW-1:0] if_rdata1, d_wdata1, d_rdata1, mem_wdata1, mem_rdata1;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .stall(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 9'h004) return 32'h0050_0093;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory returns real data only on the last cycle of an enable run.
    logic [DW-1:0] mem_arr [512];
    logic          wr_v [512];
    int            en_run;
    logic          mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) wr_v[i] <= 1'b0;
            en_run <= 0;
        end else begin
            if (mem_en && mem_we) begin
                mem_arr[mem_addr] <= mem_wdata;
                wr_v[mem_addr]    <= 1'b1;
            end
            en_run <= mem_en ? en_run + 1 : 0;
        end
    end
    assign mem_rdata  = (mem_en && en_run == int'(L) - 1)
                        ? (wr_v[mem_addr] ? mem_arr[mem_addr] : init_word(mem_addr))
                        : 32'hBAD0_0BAD;
    assign mem_rdata1 = mem_en1 ? (32'h0C0F_0000 | 32'(mem_addr1)) : 32'hBAD1_BAD1;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } op_t;

    op_t           q_op [2][$];
    bit            active [2];
    int            raise_cyc [2];
    int            ack_at [2];
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] pend_rd [2];
    logic          pend_read [2];
    logic [DW-1:0] ref_mem [512];
    int            cyc, avail, last, busy_from, busy_to;
    logic          busy_we;
    logic [AW-1:0] busy_addr;
    logic [DW-1:0] busy_wdata;
    int            ack_log_p [$];
    int            ack_log_c [$];
    int            we_cycles, en_cycles, m_rel;
    int            n_pass, n_fail, n_total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] w, input int gap);
        op_t r;
        r.we = we; r.addr = a; r.wdata = w; r.gap = gap;
        return r;
    endfunction

    function automatic int log_c(input int i);
        return (i < ack_log_c.size()) ? ack_log_c[i] : -1000;
    endfunction

    function automatic int log_p(input int i);
        return (i < ack_log_p.size()) ? ack_log_p[i] : -1;
    endfunction

    // Requester behaviour: hold req until the expected ack, then drop or issue the next op.
    task automatic drive_port(input int p);
        op_t r;
        if (active[p] && ack_at[p] == cyc) begin
            active[p] = 1'b0;
            if (p == 0) if_req = 1'b0; else d_req = 1'b0;
        end
        if (!active[p] && q_op[p].size() > 0) begin
            r = q_op[p].pop_front();
            if (r.gap > 0) begin
                r.gap--;
                q_op[p].push_front(r);
            end else begin
                active[p]    = 1'b1;
                raise_cyc[p] = cyc;
                if (p == 0) begin
                    if_req = 1'b1; if_addr = r.addr;
                end else begin
                    d_req = 1'b1; d_we = r.we; d_addr = r.addr; d_wdata = r.wdata;
                end
            end
        end
    endtask

    // One cycle: check registered outputs, drive requesters, check stall, then schedule.
    task automatic body();
        logic in_busy;
        logic e0, e1;
        int   g;
        for (int p = 0; p < 2; p++) begin
            if (ack_at[p] == cyc) begin
                if (pend_read[p]) exp_rd[p] = pend_rd[p];
                ack_log_p.push_back(p);
                ack_log_c.push_back(cyc);
            end
        end
        in_busy = (cyc >= busy_from) && (cyc <= busy_to);
        check("if_ack", 32'(if_ack), 32'(ack_at[0] == cyc));
        check("d_ack", 32'(d_ack), 32'(ack_at[1] == cyc));
        check("if_rdata", if_rdata, exp_rd[0]);
        check("d_rdata", d_rdata, exp_rd[1]);
        check("mem_en", 32'(mem_en), 32'(in_busy));
        check("mem_we", 32'(mem_we), 32'(in_busy && busy_we));
        check("mem_addr", 32'(mem_addr), in_busy ? 32'(busy_addr) : 32'h0);
        check("mem_wdata", mem_wdata, in_busy ? busy_wdata : 32'h0);
        if (mem_we) we_cycles++;
        if (mem_en) en_cycles++;
        drive_port(0);
        drive_port(1);
        #1;
        check("stall", 32'(stall), 32'((if_req && ack_at[0] != cyc) || (d_req && ack_at[1] != cyc)));
        if (cyc >= avail) begin
            e0 = if_req && ack_at[0] != cyc;
            e1 = d_req && ack_at[1] != cyc;
            if (e0 || e1) begin
                g         = (e0 && e1) ? 1 - last : (e1 ? 1 : 0);
                last      = g;
                ack_at[g] = cyc + int'(L) + 1;
                busy_from = cyc + 1;
                busy_to   = cyc + int'(L);
                avail     = cyc + int'(L) + 1;
                if (g == 0) begin
                    busy_we = 1'b0; busy_addr = if_addr; busy_wdata = '0;
                    pend_read[0] = 1'b1; pend_rd[0] = ref_mem[if_addr];
                end else begin
                    busy_we = d_we; busy_addr = d_addr; busy_wdata = d_wdata;
                    if (d_we) begin
                        ref_mem[d_addr] = d_wdata;
                        pend_read[1]    = 1'b0;
                    end else begin
                        pend_read[1] = 1'b1;
                        pend_rd[1]   = ref_mem[d_addr];
                    end
                end
            end
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            body();
        end
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while (k < budget && !(q_op[0].size() == 0 && q_op[1].size() == 0 && !active[0] && !active[1])) begin
            @(negedge clk);
            cyc++;
            body();
            k++;
        end
        check("drain_in_budget", 32'(k < budget), 32'h1);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_if_ack", 32'(if_ack), 32'h0);
        check("rst_d_ack", 32'(d_ack), 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        for (int p = 0; p < 2; p++) begin
            ack_at[p] = -1; exp_rd[p] = '0; pend_read[p] = 1'b0;
        end
        busy_from = 1; busy_to = 0; last = 0;
        @(negedge clk);
        cyc++;
        reset = 1'b1;
        avail = cyc;
        body();
    endtask

    task automatic clear_logs();
        ack_log_p.delete();
        ack_log_c.delete();
        we_cycles = 0;
        en_cycles = 0;
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        reset = 1'b0; mem_clr = 1'b1; cyc = 0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        if_req1 = 0; if_addr1 = '0; d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_wdata1 = '0;
        for (int p = 0; p < 2; p++) begin
            active[p] = 1'b0; raise_cyc[p] = 0;
        end
        for (int i = 0; i < 512; i++) ref_mem[i] = init_word(AW'(i));
        @(negedge clk);
        mem_clr = 1'b0;
        reset_pulse();

        // Single fetch.
        clear_logs();
        q_op[0].push_back(mk(1'b0, 9'h004, '0, 0));
        run_until_idle(20);
        check("t1_ack_latency", 32'(log_c(0) - raise_cyc[0]), 32'd3);
        check("t1_if_rdata", if_rdata, 32'h0050_0093);
        check("t1_en_cycles", 32'(en_cycles), 32'd2);
        run_cycles(2);

        // Store then load to the same word.
        clear_logs();
        q_op[1].push_back(mk(1'b1, 9'h010, 32'hDEAD_BEEF, 0));
        q_op[1].push_back(mk(1'b0, 9'h010, '0, 0));
        run_until_idle(30);
        check("t2_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("t2_we_cycles", 32'(we_cycles), 32'd2);
        check("t2_ack_gap", 32'(log_c(1) - log_c(0)), 32'd4);

        // Both ports held continuously after reset.
        reset_pulse();
        clear_logs();
        q_op[0].push_back(mk(1'b0, 9'h020, '0, 0));
        q_op[0].push_back(mk(1'b0, 9'h021, '0, 0));
        q_op[1].push_back(mk(1'b0, 9'h030, '0, 0));
        q_op[1].push_back(mk(1'b0, 9'h031, '0, 0));
        run_until_idle(40);
        check("t3_first_data", 32'(log_p(0)), 32'd1);
        check("t3_then_fetch", 32'(log_p(1)), 32'd0);
        check("t3_then_data", 32'(log_p(2)), 32'd1);
        check("t3_gap_a", 32'(log_c(1) - log_c(0)), 32'd3);
        check("t3_gap_b", 32'(log_c(2) - log_c(1)), 32'd3);

        // Reset in the second BUSY cycle of a fetch.
        clear_logs();
        q_op[0].push_back(mk(1'b0, 9'h040, '0, 0));
        run_cycles(3);
        reset_pulse();
        m_rel = cyc;
        run_until_idle(20);
        check("t4_ack_count", 32'(ack_log_c.size()), 32'd1);
        check("t4_ack_latency", 32'(log_c(0) - m_rel), 32'd3);
        check("t4_if_rdata", if_rdata, init_word(9'h040));

        // Data request arrives during a fetch's BUSY.
        clear_logs();
        q_op[0].push_back(mk(1'b0, 9'h050, '0, 0));
        q_op[1].push_back(mk(1'b0, 9'h060, '0, 1));
        run_until_idle(30);
        check("t5_order", 32'(log_p(1)), 32'd1);
        check("t5_d_after_if", 32'(log_c(1) - log_c(0)), 32'd3);

        // Random traffic on both ports.
        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < 2; p++) begin
                q_op[p].push_back(mk((p == 1) ? 1'($urandom_range(0, 1)) : 1'b0,
                                     AW'($urandom_range(0, 15)), DW'($urandom),
                                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0));
            end
        end
        run_until_idle(3000);
        run_cycles(3);

        // Single fetch on the MEM_LAT = 1 instance.
        @(negedge clk);
        if_req1  = 1'b1;
        if_addr1 = 9'h0AB;
        #1;
        check("l1_stall", 32'(stall1), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("l1_mem_en", 32'(mem_en1), 32'(k == 1));
            check("l1_if_ack", 32'(if_ack1), 32'(k == 2));
            if (k == 2) if_req1 = 1'b0;
        end
        check("l1_if_rdata", if_rdata1, 32'h0C0F_00AB);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
